// File: rtl/chunk_arbiter_pkg.sv
// Shared types for the chunk read arbiter: block coordinates, block kinds and tag sizing.
package chunk_arbiter_pkg;

  localparam int unsigned CoordW = 4;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
    logic [CoordW-1:0] z;
  } BlockPos;

  typedef enum logic [2:0] {
    BLOCK_AIR    = 3'd0,
    BLOCK_DIRT   = 3'd1,
    BLOCK_STONE  = 3'd2,
    BLOCK_GRASS  = 3'd3,
    BLOCK_SAND   = 3'd4,
    BLOCK_WATER  = 3'd5,
    BLOCK_WOOD   = 3'd6,
    BLOCK_LEAVES = 3'd7
  } BlockType;

  // A single lane still needs a 1-bit tag so the FIFO has something to store.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO with same-cycle push/pop, first-word-fall-through read data.
module tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    do_push  = push_i && ((count_q != CntW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/chunk_arbiter.sv
// Round-robin arbiter sharing one chunk memory among NUM_VTU traversal units, with in-order
// tag tracking so each returned block is steered back to its requester.
module chunk_arbiter
  import chunk_arbiter_pkg::*;
#(
  parameter int unsigned NUM_VTU = 4,
  parameter int unsigned TAG_W   = tag_width(NUM_VTU),
  localparam int unsigned CntW   = $clog2(NUM_VTU + 1)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  BlockPos            req_addr [NUM_VTU],
  input  logic [NUM_VTU-1:0] req_read_enable,
  input  logic [NUM_VTU-1:0] req_flush,
  output BlockType           req_out,
  output logic [NUM_VTU-1:0] req_valid,
  output BlockPos            mem_addr,
  output logic               mem_read_enable,
  input  BlockType           mem_out,
  input  logic               mem_valid,
  output logic [CntW-1:0]    outstanding,
  output logic               err_orphan
);

  logic [NUM_VTU-1:0] pending_q, pending_d;
  logic [NUM_VTU-1:0] stale_q, stale_d;
  logic [TAG_W-1:0]   last_grant_q, last_grant_d;
  BlockPos            mem_addr_q, mem_addr_d;
  logic               mem_re_q, mem_re_d;
  BlockType           req_out_q, req_out_d;
  logic [NUM_VTU-1:0] req_valid_q, req_valid_d;
  logic               err_orphan_q, err_orphan_d;

  logic [NUM_VTU-1:0] eligible;
  logic               grant;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   lane_idx;
  int unsigned        lane;

  logic               fifo_pop;
  logic               fifo_empty;
  logic [TAG_W-1:0]   resp_tag;
  logic [CntW-1:0]    fifo_count;
  logic               drop;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    eligible  = req_read_enable & ~pending_q & ~req_flush;
    grant     = 1'b0;
    grant_idx = last_grant_q;
    lane      = 0;
    lane_idx  = '0;
    for (int unsigned k = 1; k <= NUM_VTU; k++) begin
      lane     = (32'(last_grant_q) + k) % NUM_VTU;
      lane_idx = TAG_W'(lane);
      if (!grant && eligible[lane_idx]) begin
        grant     = 1'b1;
        grant_idx = lane_idx;
      end
    end
  end

  always_comb begin
    fifo_pop     = mem_valid && !fifo_empty;
    // A flush landing on the very cycle its response pops still discards that response.
    drop         = stale_q[resp_tag] || req_flush[resp_tag];
    pending_d    = pending_q;
    stale_d      = stale_q | (req_flush & pending_q);
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = grant;
    req_out_d    = req_out_q;
    req_valid_d  = '0;
    err_orphan_d = err_orphan_q || (mem_valid && fifo_empty);

    if (fifo_pop) begin
      pending_d[resp_tag] = 1'b0;
      stale_d[resp_tag]   = 1'b0;
      if (!drop) begin
        req_valid_d[resp_tag] = 1'b1;
        req_out_d             = mem_out;
      end
    end

    if (grant) begin
      pending_d[grant_idx] = 1'b1;
      mem_addr_d           = req_addr[grant_idx];
      last_grant_d         = grant_idx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q    <= '0;
      stale_q      <= '0;
      last_grant_q <= TAG_W'(NUM_VTU - 1);
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      req_out_q    <= BLOCK_AIR;
      req_valid_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      stale_q      <= stale_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      req_out_q    <= req_out_d;
      req_valid_q  <= req_valid_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  tag_fifo #(
    .WIDTH(TAG_W),
    .DEPTH(NUM_VTU)
  ) u_tag_fifo (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .push_i (grant),
    .wdata_i(grant_idx),
    .pop_i  (fifo_pop),
    .rdata_o(resp_tag),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign mem_addr        = mem_addr_q;
  assign mem_read_enable = mem_re_q;
  assign req_out         = req_out_q;
  assign req_valid       = req_valid_q;
  assign outstanding     = fifo_count;
  assign err_orphan      = err_orphan_q;

endmodule

// File: tb/tb_chunk_arbiter.sv
// Bench for chunk_arbiter: directed scenarios plus random traffic against a queue-based model
// of the arbiter and an in-order chunk with variable latency.
module tb_chunk_arbiter;
  import chunk_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int PW = $bits(BlockPos);

  logic           clk_in = 1'b0;
  logic           rst_in;
  BlockPos        req_addr [N];
  logic [N-1:0]   req_read_enable;
  logic [N-1:0]   req_flush;
  BlockType       req_out;
  logic [N-1:0]   req_valid;
  BlockPos        mem_addr;
  logic           mem_read_enable;
  BlockType       mem_out;
  logic           mem_valid;
  logic [2:0]     outstanding;
  logic           err_orphan;

  chunk_arbiter #(.NUM_VTU(N)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_addr       (req_addr),
    .req_read_enable(req_read_enable),
    .req_flush      (req_flush),
    .req_out        (req_out),
    .req_valid      (req_valid),
    .mem_addr       (mem_addr),
    .mem_read_enable(mem_read_enable),
    .mem_out        (mem_out),
    .mem_valid      (mem_valid),
    .outstanding    (outstanding),
    .err_orphan     (err_orphan)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 3;
  bit orphan_pulse = 1'b0;

  // Reference model: outstanding lanes in issue order, plus per-lane bookkeeping.
  int           tagq[$];
  bit           m_pend  [N];
  bit           m_stale [N];
  int           m_last;
  logic         m_mre;
  BlockPos      m_maddr;
  logic [N-1:0] m_rv;
  BlockType     m_rout;
  logic         m_err;

  // Chunk model: responses due at a given cycle, strictly in order.
  int       due_q[$];
  BlockType dat_q[$];
  int       last_due = 0;

  function automatic BlockType blk_of(input BlockPos p);
    return BlockType'(3'((int'(p.x) + int'(p.y) + int'(p.z) + 3) % 8));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    tagq.delete();
    for (int i = 0; i < N; i++) begin
      m_pend[i]  = 1'b0;
      m_stale[i] = 1'b0;
    end
    m_last  = N - 1;
    m_mre   = 1'b0;
    m_maddr = '0;
    m_rv    = '0;
    m_rout  = BLOCK_AIR;
    m_err   = 1'b0;
    due_q.delete();
    dat_q.delete();
    last_due = cyc;
  endtask

  task automatic model_edge();
    int g;
    int t;
    int l;
    if (rst_in) begin
      m_reset();
      return;
    end
    g = -1;
    for (int k = 1; k <= N; k++) begin
      l = (m_last + k) % N;
      if (g < 0 && req_read_enable[l] && !m_pend[l] && !req_flush[l]) g = l;
    end
    for (int i = 0; i < N; i++) if (req_flush[i] && m_pend[i]) m_stale[i] = 1'b1;
    m_rv = '0;
    if (mem_valid) begin
      if (tagq.size() == 0) begin
        m_err = 1'b1;
      end else begin
        t = tagq.pop_front();
        m_pend[t] = 1'b0;
        if (m_stale[t]) m_stale[t] = 1'b0;
        else begin
          m_rv[t] = 1'b1;
          m_rout  = mem_out;
        end
      end
    end
    m_mre = (g >= 0);
    if (g >= 0) begin
      m_maddr   = req_addr[g];
      tagq.push_back(g);
      m_pend[g] = 1'b1;
      m_last    = g;
    end
  endtask

  task automatic drive_chunk();
    mem_valid = 1'b0;
    mem_out   = BlockType'(3'($urandom));
    if (orphan_pulse) begin
      mem_valid = 1'b1;
      mem_out   = BLOCK_STONE;
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      mem_valid = 1'b1;
      mem_out   = dat_q.pop_front();
      void'(due_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    chk("mem_read_enable", 32'(mem_read_enable), 32'(m_mre));
    chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
    chk("req_valid", 32'(req_valid), 32'(m_rv));
    chk("req_out", 32'(req_out), 32'(m_rout));
    chk("outstanding", 32'(outstanding), 32'(tagq.size()));
    chk("err_orphan", 32'(err_orphan), 32'(m_err));
  endtask

  task automatic step();
    int d;
    drive_chunk();
    model_edge();
    @(posedge clk_in);
    #1;
    cyc++;
    check_outputs();
    if (m_mre) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      due_q.push_back(d);
      dat_q.push_back(blk_of(m_maddr));
      last_due = d;
    end
  endtask

  task automatic do_reset();
    rst_in          = 1'b1;
    req_read_enable = '0;
    req_flush       = '0;
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in          = 1'b1;
    req_read_enable = '0;
    req_flush       = '0;
    mem_valid       = 1'b0;
    mem_out         = BLOCK_AIR;
    for (int i = 0; i < N; i++) req_addr[i] = '0;
    m_reset();
    do_reset();
    do_reset();

    // Single read from lane 2, chunk latency 3.
    lat             = 3;
    req_addr[2]     = '{x: 4'd1, y: 4'd2, z: 4'd3};
    req_read_enable = 4'b0100;
    step();
    chk("t1_mem_re", 32'(mem_read_enable), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h123);
    req_read_enable = '0;
    repeat (4) step();
    chk("t1_req_valid", 32'(req_valid), 32'b0100);
    chk("t1_req_out", 32'(req_out), 32'(BLOCK_DIRT));
    step();
    chk("t1_outstanding", 32'(outstanding), 32'd0);

    // All lanes contend continuously.
    do_reset();
    lat = 6;
    for (int i = 0; i < N; i++) req_addr[i] = '{x: 4'(i), y: 4'd7, z: 4'd9};
    req_read_enable = '1;
    for (int i = 0; i < N; i++) begin
      step();
      chk("t2_grant_order", 32'(mem_addr.x), 32'(i));
    end
    chk("t2_outstanding_full", 32'(outstanding), 32'd4);
    repeat (10) step();
    req_read_enable = '0;
    repeat (10) step();

    // Flush lane 1 while its read is in flight.
    do_reset();
    lat             = 5;
    req_addr[1]     = '{x: 4'd2, y: 4'd2, z: 4'd2};
    req_read_enable = 4'b0010;
    step();
    step();
    req_flush = 4'b0010;
    step();
    req_flush = '0;
    chk("t3_still_pending", 32'(outstanding), 32'd1);
    repeat (4) step();
    chk("t3_dropped", 32'(req_valid), 32'd0);
    chk("t3_no_regrant_yet", 32'(mem_read_enable), 32'd0);
    step();
    chk("t3_regrant", 32'(mem_read_enable), 32'd1);
    req_read_enable = '0;
    repeat (10) step();

    // Grant and response in the same cycle.
    do_reset();
    lat = 1;
    for (int i = 0; i < N; i++) req_addr[i] = '{x: 4'(i + 1), y: 4'd3, z: 4'd4};
    req_read_enable = 4'b0001;
    step();
    req_read_enable = 4'b0100;
    step();
    req_read_enable = 4'b1000;
    step();
    chk("t4_outstanding_same", 32'(outstanding), 32'd2);
    chk("t4_routed", 32'(req_valid), 32'b0001);
    chk("t4_grant_lane3", 32'(mem_addr.x), 32'd4);
    req_read_enable = '0;
    repeat (8) step();

    // Response with nothing outstanding.
    do_reset();
    orphan_pulse = 1'b1;
    step();
    orphan_pulse = 1'b0;
    chk("t5_orphan_set", 32'(err_orphan), 32'd1);
    chk("t5_no_valid", 32'(req_valid), 32'd0);
    chk("t5_fifo_empty", 32'(outstanding), 32'd0);
    step();
    chk("t5_orphan_sticky", 32'(err_orphan), 32'd1);

    // Reset with three reads in flight.
    lat = 8;
    for (int i = 0; i < N; i++) req_addr[i] = '{x: 4'(i + 5), y: 4'd1, z: 4'd1};
    req_read_enable = 4'b0111;
    repeat (3) step();
    chk("t6_inflight", 32'(outstanding), 32'd3);
    rst_in          = 1'b1;
    req_read_enable = '1;
    step();
    rst_in = 1'b0;
    chk("t6_rst_mem_re", 32'(mem_read_enable), 32'd0);
    chk("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_rst_req_valid", 32'(req_valid), 32'd0);
    chk("t6_rst_req_out", 32'(req_out), 32'(BLOCK_AIR));
    chk("t6_rst_outstanding", 32'(outstanding), 32'd0);
    chk("t6_rst_err_orphan", 32'(err_orphan), 32'd0);
    step();
    chk("t6_first_lane0", 32'(mem_addr.x), 32'd5);
    req_read_enable = '0;
    repeat (12) step();

    // Random traffic with flushes and varying chunk latency.
    for (int c = 0; c < 400; c++) begin
      lat = $urandom_range(1, 4);
      for (int i = 0; i < N; i++) begin
        if (!req_read_enable[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_read_enable[i] = 1'b1;
            req_addr[i]        = BlockPos'(PW'($urandom));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req_read_enable[i] = 1'b0;
        end
        req_flush[i] = ($urandom_range(0, 31) == 0);
      end
      step();
    end
    req_read_enable = '0;
    req_flush       = '0;
    repeat (12) step();
    chk("drain_empty", 32'(outstanding), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chunk_arbiter.md
# chunk_arbiter

Shares one `chunk` voxel memory between `NUM_VTU` voxel traversal units. Each VTU issues block reads. The arbiter grants one read per cycle in round-robin order and tracks outstanding reads in an in-order tag FIFO. It steers each returned block back to the VTU that asked for it. It sits between the VTU instances and a single `chunk` instance in the orchestrator, replacing one chunk per VTU.

## Interface
Parameters:
- `NUM_VTU`, default 4: number of requester lanes, ≥1.
- `TAG_W`, default `$clog2(NUM_VTU)` (minimum 1): lane index width.

Ports:
- `clk_in` in, 1: the only clock.
- `rst_in` in, 1: reset, synchronous, active-high.
- `req_addr` in, `[NUM_VTU]` BlockPos: per-lane read address. Held stable while `req_read_enable` is high.
- `req_read_enable` in, `[NUM_VTU]`: per-lane read request, a level signal.
- `req_flush` in, `[NUM_VTU]`: per-lane abort, pulsed when that VTU is reset mid-ray.
- `req_out` out, BlockType: returned block, shared by all lanes.
- `req_valid` out, `[NUM_VTU]`: one-cycle pulse, one-hot, qualifies `req_out` for that lane.
- `mem_addr` out, BlockPos: to `chunk.addr`.
- `mem_read_enable` out, 1: to `chunk.read_enable`, one-cycle pulse per grant.
- `mem_out` in, BlockType: from `chunk.out`.
- `mem_valid` in, 1: from `chunk.valid`.
- `outstanding` out, `$clog2(NUM_VTU+1)`: current tag FIFO occupancy.
- `err_orphan` out, 1: sticky flag; set by `mem_valid` while the FIFO is empty.

## Operation
Per-lane state:
- `pending[i]`: lane has a read in flight.
- `stale[i]`: lane's in-flight read has been flushed.

Eligibility and grant:
- A lane is eligible when `req_read_enable[i] && !pending[i] && !req_flush[i]`.
- Round-robin search starts at `last_grant+1` and wraps modulo `NUM_VTU`. The first eligible lane wins.
- On a grant:
  - register `mem_addr <= req_addr[g]` and pulse `mem_read_enable`;
  - push tag `g` into the FIFO;
  - set `pending[g]`;
  - set `last_grant <= g`.
- With no eligible lane: `mem_read_enable` is 0 and `last_grant` is unchanged.

Response:
- On `mem_valid`, pop tag `t` and clear `pending[t]`.
- If `stale[t]`: drop the data, clear `stale[t]`, and drive no `req_valid`.
- Otherwise: register `req_out <= mem_out` and `req_valid <= onehot(t)`.
- The chunk returns exactly one `mem_valid` per `mem_read_enable`, in order. The FIFO depth is `NUM_VTU`, since each lane has at most one read outstanding, so it cannot overflow.

Flush (`req_flush[i]`):
- If the lane is pending, set `stale[i]`.
- Flush blocks a grant to that lane in the same cycle.
- If flush coincides with `mem_valid` popping tag `i`, the response is dropped and `stale[i]` stays clear.
- A lane that is pending and stale is ineligible until its dropped response returns.

Boundary cases:
- `mem_valid` with an empty FIFO: ignore the data, set `err_orphan`, leave the FIFO unchanged.
- A grant and `mem_valid` in the same cycle: push and pop both happen, and occupancy is unchanged.
- `NUM_VTU=1`: always grant lane 0 when eligible.

Reset values:
- `mem_read_enable=0`, `mem_addr=0`.
- `req_valid=0`, `req_out=BLOCK_AIR`.
- `outstanding=0`, `err_orphan=0`.
- `pending=0`, `stale=0`.
- FIFO empty, `last_grant=NUM_VTU-1` so lane 0 is first.

Reset mid-operation discards all in-flight tags. The owner must reset `chunk` in the same cycle.

## Timing
- Request to `mem_read_enable`: 1 cycle. `req_read_enable` is sampled in cycle N; grant is registered at N+1.
- `mem_valid` to `req_valid`: 1 cycle, registered.
- Total added latency: 2 cycles over the bare chunk latency.
- Throughput: 1 grant per cycle across all lanes.
- `pending[t]` clears in the cycle `req_valid[t]` is driven. A lane seen with `req_read_enable` high in the cycle after its `req_valid` pulse has made a new request. Requesters must drop `req_read_enable` on seeing `req_valid` unless they want another read.
- Fairness: under continuous contention, a lane waits at most `NUM_VTU-1` grants.

## Structure
- `BlockPos` and `BlockType` come from `types.sv`. Add `CHUNK_ARB_TAG_W` there if other blocks need tags.
- Sub-module: `tag_fifo`, a synchronous FIFO with parameters `WIDTH`/`DEPTH`, simultaneous push and pop, and an `empty`/`count` output. Round-robin selection stays inline.

## Test plan
- `NUM_VTU=4`; lane 2 requests addr (1,2,3); chunk returns `BLOCK_DIRT` 3 cycles later. Expect `mem_read_enable` at N+1 with `mem_addr`=(1,2,3) and `req_valid=4'b0100` one cycle after `mem_valid`. Other lanes see no `req_valid`.
- All 4 lanes request simultaneously and continuously. Expect grant order 0,1,2,3 on consecutive cycles, `outstanding` reaching 4, and no lane granted twice before its response.
- Lane 1 is granted, then `req_flush[1]` is pulsed before `mem_valid`. Expect the response dropped with no `req_valid[1]`, and lane 1 regranted only after the drop.
- A grant and a `mem_valid` in the same cycle. Expect `outstanding` unchanged and the correct tag routed.
- `mem_valid` with an empty FIFO. Expect `err_orphan=1` and sticky, and all `req_valid` low.
- `rst_in` asserted with 3 reads in flight. Next cycle: all outputs at reset values, `outstanding=0`, and the first grant goes to lane 0.
